// File: rtl/fpu_conv_row_sequencer.sv
// rtl/fpu_conv_row_sequencer.sv - walks valid 3x3 conv output rows, emitting row fetch/store commands
// Optional: define FPU_SEQ_ROW_REUSE_EN to fetch only the new source row for output rows after the first.
module fpu_conv_row_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [DIM_W-1:0]  image_width,
   input  logic [DIM_W-1:0]  image_height,
   input  logic [ADDR_W-1:0] start_address,
   input  logic [ADDR_W-1:0] result_address,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DIM_W-1:0]  cmd_len,
   output logic [1:0]        cmd_slot,
   input  logic              row_done,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_FETCH, S_WAIT_ROW, S_STORE, S_NEXT, S_FINISH
   } state_t;

   state_t            state;
   logic [DIM_W-1:0]  width_q;
   logic [DIM_W-1:0]  height_q;
   logic [DIM_W-1:0]  out_row;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] result_q;
   logic [ADDR_W-1:0] res_base;
   logic [1:0]        fetch_left;
`ifdef FPU_SEQ_ROW_REUSE_EN
   // Address/slot of the most recently accepted fetch, i.e. source row r+2.
   logic [ADDR_W-1:0] tail_addr;
   logic [1:0]        tail_slot;
`else
   logic [ADDR_W-1:0] row_base;
   logic [1:0]        row_slot;
`endif

   logic [ADDR_W-1:0] w_ext;
   logic [DIM_W-1:0]  out_w;
   logic [ADDR_W-1:0] out_w_ext;

   assign w_ext     = ADDR_W'(width_q);
   assign out_w     = width_q - DIM_W'(2);
   assign out_w_ext = ADDR_W'(out_w);

   function automatic logic [1:0] slot_inc(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cmd_valid  <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_addr   <= '0;
         cmd_len    <= '0;
         cmd_slot   <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         width_q    <= '0;
         height_q   <= '0;
         out_row    <= '0;
         start_q    <= '0;
         result_q   <= '0;
         res_base   <= '0;
         fetch_left <= 2'd0;
`ifdef FPU_SEQ_ROW_REUSE_EN
         tail_addr  <= '0;
         tail_slot  <= 2'd0;
`else
         row_base   <= '0;
         row_slot   <= 2'd0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_valid) begin
                  width_q  <= image_width;
                  height_q <= image_height;
                  start_q  <= start_address;
                  result_q <= result_address;
                  busy     <= 1'b1;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (width_q < DIM_W'(3) || height_q < DIM_W'(3)) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  out_row    <= '0;
                  res_base   <= result_q;
                  cmd_valid  <= 1'b1;
                  cmd_write  <= 1'b0;
                  cmd_addr   <= start_q;
                  cmd_len    <= width_q;
                  cmd_slot   <= 2'd0;
                  fetch_left <= 2'd2;
`ifndef FPU_SEQ_ROW_REUSE_EN
                  row_base   <= start_q;
                  row_slot   <= 2'd0;
`endif
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (cmd_ready) begin
`ifdef FPU_SEQ_ROW_REUSE_EN
                  tail_addr <= cmd_addr;
                  tail_slot <= cmd_slot;
`endif
                  if (fetch_left == 2'd0) begin
                     cmd_valid <= 1'b0;
                     state     <= S_WAIT_ROW;
                  end else begin
                     cmd_addr   <= cmd_addr + w_ext;
                     cmd_slot   <= slot_inc(cmd_slot);
                     fetch_left <= fetch_left - 2'd1;
                  end
               end
            end
            S_WAIT_ROW: begin
               if (row_done) begin
                  cmd_valid <= 1'b1;
                  cmd_write <= 1'b1;
                  cmd_addr  <= res_base;
                  cmd_len   <= out_w;
                  cmd_slot  <= 2'd0;
                  state     <= S_STORE;
               end
            end
            S_STORE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  cmd_write <= 1'b0;
                  res_base  <= res_base + out_w_ext;
                  state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (out_row == height_q - DIM_W'(3)) begin
                  state <= S_FINISH;
               end else begin
                  out_row   <= out_row + DIM_W'(1);
                  cmd_valid <= 1'b1;
                  cmd_write <= 1'b0;
                  cmd_len   <= width_q;
`ifdef FPU_SEQ_ROW_REUSE_EN
                  cmd_addr   <= tail_addr + w_ext;
                  cmd_slot   <= slot_inc(tail_slot);
                  fetch_left <= 2'd0;
`else
                  cmd_addr   <= row_base + w_ext;
                  cmd_slot   <= slot_inc(row_slot);
                  fetch_left <= 2'd2;
                  row_base   <= row_base + w_ext;
                  row_slot   <= slot_inc(row_slot);
`endif
                  state     <= S_FETCH;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
